multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle MIPS control decoder. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. It drives per-cycle datapath strobes for a shared-memory multi-cycle datapath and supports memory wait states through a ready handshake. It adds an illegal-opcode trap, a memory-timeout trap and a retired-instruction counter; it sits between the instruction register and the datapath muxes and enables.

---
 rtl/multicycle_control.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath strobes.
// Latency: R-type/imm/sw 4, lw 5, branch/jump 3 cycles plus one cycle per memory wait state.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR; optional timeout traps after MEM_TIMEOUT waits.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT  = 0,
  parameter bit          ILLEGAL_TRAP = 1'b1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             BranchNe,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IMMEX  = 4'd10;
  localparam logic [3:0] S_IMMWB  = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  logic [3:0]       state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;

  logic [5:0] opcode;
  logic       is_rtype, is_lw, is_sw, is_beq, is_bne, is_j, is_addi, is_imm, is_known;
  logic       in_wait_state, timeout_hit;
  logic       unused_inst_bits;

  assign opcode           = inst[31:26];
  assign unused_inst_bits = ^inst[25:0];

  assign is_rtype = (opcode == 6'b000000);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_bne   = (opcode == 6'b000101);
  assign is_j     = (opcode == 6'b000010);
  assign is_addi  = (opcode == 6'b001000);
  assign is_imm   = is_addi || (opcode == 6'b001010) || (opcode == 6'b001011) ||
                    (opcode == 6'b001100) || (opcode == 6'b001101) || (opcode == 6'b001110);
  assign is_known = is_rtype || is_lw || is_sw || is_beq || is_bne || is_j || is_imm;

  // A memory wait only counts in the three states that talk to memory; ready on the same cycle beats the trap.
  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout_hit   = (MEM_TIMEOUT != 0) && in_wait_state && !mem_ready && (wait_q == TIMEOUT);

  // Moore strobes decoded from the registered state; write strobes are masked while reset is asserted.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    BranchNe    = 1'b0;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        instr_done = !is_known && !ILLEGAL_TRAP;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNe    = is_bne;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = is_addi ? 2'b00 : 2'b11;
      end
      S_IMMWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
    if (!rst_n) begin
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      PCWriteCond = 1'b0;
    end
  end

  // Next-state, sticky trap causes, wait counter and retired-instruction count.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : (timeout_hit ? S_TRAP : S_FETCH);
      S_DECODE: begin
        if (is_rtype)           state_d = S_EXEC;
        else if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_beq || is_bne) state_d = S_BRANCH;
        else if (is_j)          state_d = S_JUMP;
        else if (is_imm)        state_d = S_IMMEX;
        else if (ILLEGAL_TRAP) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else                state_d = S_FETCH;
      end
      S_MEMADR: state_d = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : (timeout_hit ? S_TRAP : S_MEMRD);
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : (timeout_hit ? S_TRAP : S_MEMWR);
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
    if (timeout_hit) mem_err_d = 1'b1;

    wait_d = wait_q;
    if (state_d != state_q) wait_d = 16'd0;
    else if (in_wait_state && !mem_ready && (wait_q != 16'hFFFF)) wait_d = wait_q + 16'd1;

    instret_d = instret_q + (instr_done ? CNT_W'(1) : CNT_W'(0));
  end

  // Registered state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= 16'd0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign mem_err = mem_err_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
// Bench for multicycle_control: two instances (trap+timeout=3, no-op illegal+no timeout, 4-bit counter)
// checked each cycle against an instruction-sequence model, plus directed literal checks.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [31:0] inst  [2];
  logic        rdy   [2];
  logic [23:0] outs  [2];
  logic [31:0] ir    [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // outs layout: [23]PCWrite [22]PCWriteCond [21]IorD [20]MemRead [19]MemWrite [18]IRWrite
  // [17]MemtoReg [16]ALUSrcA [15]RegWrite [14]RegDst [13]BranchNe [12:11]ALUOp [10:9]ALUSrcB
  // [8:7]PCSource [6:3]state [2]instr_done [1]illegal [0]mem_err
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned TO = (g == 0) ? 3 : 0;
    localparam bit          IT = (g == 0);
    localparam int unsigned CW = (g == 0) ? 32 : 4;
    logic pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, bne, done, ill, merr;
    logic [1:0] aop, asb, pcs;
    logic [3:0] st;
    logic [CW-1:0] cnt;
    multicycle_control #(.MEM_TIMEOUT(TO), .ILLEGAL_TRAP(IT), .CNT_W(CW)) u_dut (
      .clk(clk), .rst_n(rst_n[g]), .inst(inst[g]), .mem_ready(rdy[g]),
      .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mr), .MemWrite(mw),
      .IRWrite(irw), .MemtoReg(m2r), .ALUSrcA(asa), .RegWrite(rw), .RegDst(rd),
      .BranchNe(bne), .ALUOp(aop), .ALUSrcB(asb), .PCSource(pcs), .state(st),
      .instr_done(done), .illegal(ill), .mem_err(merr), .instret(cnt));
    assign outs[g] = {pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, bne, aop, asb, pcs, st, done, ill, merr};
    assign ir[g]   = 32'(cnt);
  end

  function automatic int to_of(input int k);
    return (k == 0) ? 3 : 0;
  endfunction
  function automatic bit it_of(input int k);
    return (k == 0);
  endfunction
  function automatic logic [31:0] mask_of(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  // 0 R, 1 lw, 2 sw, 3 beq, 4 bne, 5 j, 6 addi, 7 other immediate, 8 unknown
  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b000101: return 4;
      6'b000010: return 5;
      6'b001000: return 6;
      6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110: return 7;
      default:   return 8;
    endcase
  endfunction

  // Model: current step, the list of steps the decoded instruction walks after DECODE, wait count, flags.
  int          m_st  [2];
  int          m_seq [2][3];
  int          m_len [2];
  int          m_pos [2];
  int          m_w   [2];
  bit          m_ill [2];
  bit          m_merr[2];
  logic [31:0] m_ir  [2];

  function automatic bit is_mem_step(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  // An instruction retires on its final step (MEMWR only once memory accepts), or at DECODE for a no-op unknown.
  function automatic bit exp_done(input int k);
    int s;
    s = m_st[k];
    if (s == 1) return (op_class(inst[k][31:26]) == 8) && !it_of(k);
    if (s == 0 || s == 12) return 1'b0;
    if (m_pos[k] < m_len[k]) return 1'b0;
    if (s == 5) return rdy[k];
    return 1'b1;
  endfunction

  function automatic logic [23:0] exp_outs(input int k);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, bne;
    logic [1:0] aop, asb, pcs;
    int c;
    c = op_class(inst[k][31:26]);
    {pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, bne} = '0;
    aop = 2'b00; asb = 2'b00; pcs = 2'b00;
    case (m_st[k])
      0:  begin mr = 1; asb = 2'b01; irw = rdy[k]; pcw = rdy[k]; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin iord = 1; mr = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bne = (c == 4); end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; aop = (c == 6) ? 2'b00 : 2'b11; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, bne, aop, asb, pcs,
            4'(m_st[k]), exp_done(k), m_ill[k], m_merr[k]};
  endfunction

  task automatic set_seq(input int k, input int n, input int a, input int b, input int c);
    m_len[k] = n; m_seq[k][0] = a; m_seq[k][1] = b; m_seq[k][2] = c;
  endtask

  task automatic model_step(input int k);
    int nx;
    int c;
    bit d;
    d = exp_done(k);
    if (!rst_n[k]) begin
      m_st[k] = 0; m_len[k] = 0; m_pos[k] = 0; m_w[k] = 0;
      m_ill[k] = 0; m_merr[k] = 0; m_ir[k] = 32'd0;
      return;
    end
    if (d) m_ir[k] = (m_ir[k] + 32'd1) & mask_of(k);
    if (m_st[k] == 12) nx = 12;
    else if (is_mem_step(m_st[k]) && !rdy[k]) begin
      if (to_of(k) != 0 && m_w[k] == to_of(k)) begin nx = 12; m_merr[k] = 1; end
      else nx = m_st[k];
    end else if (m_st[k] == 0) nx = 1;
    else if (m_st[k] == 1) begin
      c = op_class(inst[k][31:26]);
      case (c)
        0: set_seq(k, 2, 6, 7, 0);
        1: set_seq(k, 3, 2, 3, 4);
        2: set_seq(k, 2, 2, 5, 0);
        3, 4: set_seq(k, 1, 8, 0, 0);
        5: set_seq(k, 1, 9, 0, 0);
        6, 7: set_seq(k, 2, 10, 11, 0);
        default: begin
          if (it_of(k)) begin set_seq(k, 1, 12, 0, 0); m_ill[k] = 1; end
          else set_seq(k, 0, 0, 0, 0);
        end
      endcase
      m_pos[k] = 0;
      if (m_len[k] > 0) begin nx = m_seq[k][0]; m_pos[k] = 1; end
      else nx = 0;
    end else if (m_pos[k] < m_len[k]) begin
      nx = m_seq[k][m_pos[k]];
      m_pos[k] = m_pos[k] + 1;
    end else nx = 0;
    if (nx != m_st[k]) m_w[k] = 0;
    else if (is_mem_step(m_st[k]) && !rdy[k]) m_w[k] = m_w[k] + 1;
    m_st[k] = nx;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model; in reset only the forced-low strobes are meaningful.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        if (rst_n[k]) begin
          chk($sformatf("outs%0d", k), 32'(outs[k]), 32'(exp_outs(k)));
          chk($sformatf("instret%0d", k), ir[k], m_ir[k]);
        end else begin
          chk($sformatf("rst_strobes%0d", k),
              32'({outs[k][23], outs[k][22], outs[k][20], outs[k][19], outs[k][18], outs[k][15]}), 32'd0);
        end
      end
    end
  end

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    rdy[k]   = 1'b1;
    @(posedge clk); #1;
    rst_n[k] = 1'b1;
  endtask

  task automatic dir_run(input int k, input logic [5:0] op, input string nm, input int n,
                         input logic [31:0] rdy_pat, input logic [127:0] st_pat,
                         output logic [23:0] last);
    inst[k] = {op, 26'($urandom)};
    last = '0;
    for (int c = 0; c < n; c++) begin
      rdy[k] = rdy_pat[c];
      @(negedge clk);
      chk($sformatf("%s_state%0d", nm, c), 32'(outs[k][6:3]), 32'(st_pat[c*4 +: 4]));
      last = outs[k];
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [12];
    int idx;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
            6'b001000, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110};
    idx = $urandom_range(0, 13);
    if (idx < 12) return {ops[idx], 26'($urandom)};
    return $urandom;
  endfunction

  initial begin
    logic [23:0]  last;
    logic [127:0] pat;
    int           trapc [2];
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; rdy[k] = 1'b1; inst[k] = 32'd0; trapc[k] = 0;
    end
    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b1;

    // Reset state of instance 0 while reset is still held.
    @(negedge clk);
    chk("rst_state", 32'(outs[0][6:3]), 32'd0);
    chk("rst_instret", ir[0], 32'd0);
    chk("rst_flags", 32'(outs[0][1:0]), 32'd0);
    chk("rst_memread_forced", 32'(outs[0][20]), 32'd0);
    @(posedge clk); #1;

    // Instance 1: no-op illegal, no timeout.
    do_reset(1);
    dir_run(1, 6'b000000, "rtype", 4, 32'hFFFF_FFFF, 128'h7610, last);
    chk("rtype_regdst_regwrite", 32'({last[14], last[15]}), 32'h3);
    chk("rtype_instret", ir[1], 32'd1);
    do_reset(1);
    dir_run(1, 6'b100011, "lw", 7, 32'h67, 128'h4333210, last);
    chk("lw_memtoreg_regwrite", 32'({last[17], last[15]}), 32'h3);
    chk("lw_instret", ir[1], 32'd1);
    do_reset(1);
    dir_run(1, 6'b000101, "bne", 3, 32'hFFFF_FFFF, 128'h810, last);
    chk("bne_pcwc_pcsrc_bne", 32'({last[22], last[8:7], last[13]}), 32'b1011);
    do_reset(1);
    dir_run(1, 6'b000100, "beq", 3, 32'hFFFF_FFFF, 128'h810, last);
    chk("beq_branchne", 32'(last[13]), 32'd0);
    do_reset(1);
    dir_run(1, 6'b000010, "j", 3, 32'hFFFF_FFFF, 128'h910, last);
    chk("j_pcwrite_pcsrc", 32'({last[23], last[8:7]}), 32'b110);
    do_reset(1);
    dir_run(1, 6'b111111, "noop", 3, 32'hFFFF_FFFF, 128'h010, last);
    chk("noop_instret", ir[1], 32'd1);
    rst_n[1] = 1'b0;

    // Instance 0: illegal trap, timeout of 3.
    do_reset(0);
    pat = '0;
    pat[7:4] = 4'h1;
    for (int i = 2; i < 24; i++) pat[i*4 +: 4] = 4'hC;
    dir_run(0, 6'b111111, "trap", 24, 32'hFFFF_FFFF, pat, last);
    chk("trap_illegal", 32'(last[1]), 32'd1);
    chk("trap_strobes", 32'(last[23:7]), 32'd0);
    chk("trap_instret", ir[0], 32'd0);
    do_reset(0);
    dir_run(0, 6'b000000, "tmo", 5, 32'h0, 128'hC0000, last);
    chk("tmo_mem_err", 32'(last[0]), 32'd1);
    do_reset(0);
    dir_run(0, 6'b000000, "tmo_ok", 5, 32'h18, 128'h10000, last);
    chk("tmo_ok_mem_err", 32'(last[0]), 32'd0);
    do_reset(0);
    dir_run(0, 6'b000000, "pre", 4, 32'hFFFF_FFFF, 128'h7610, last);
    chk("pre_instret", ir[0], 32'd1);
    dir_run(0, 6'b101011, "sw", 3, 32'hFFFF_FFFF, 128'h210, last);
    rdy[0] = 1'b1;
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("swrst_state", 32'(outs[0][6:3]), 32'd5);
    chk("swrst_memwrite", 32'(outs[0][19]), 32'd0);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("swrst_after_state", 32'(outs[0][6:3]), 32'd0);
    chk("swrst_after_instret", ir[0], 32'd0);
    @(posedge clk); #1;

    // Random traffic on both instances.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        rst_n[k] = 1'b1;
        if (m_st[k] == 12) trapc[k]++;
        else trapc[k] = 0;
        if (trapc[k] > 22 || $urandom_range(0, 299) == 0) begin
          rst_n[k] = 1'b0;
          trapc[k] = 0;
        end
        rdy[k] = ($urandom_range(0, 3) != 0);
        if (m_st[k] == 0) inst[k] = rand_inst();
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
